// File: rtl/player_move_ctrl.sv
// Player movement controller: decodes W/A/S/D from four HID usage bytes,
// arbitrates a single active direction and emits frame-paced step pulses
// with a first step, a repeat delay and a steady auto-repeat rate.
module player_move_ctrl #(
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic [31:0] keycode,
  output logic [1:0]  dir,
  output logic        step,
  output logic        moving
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    DELAY,
    REPEAT
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic        step_q, step_d;
  logic [3:0]  key_dec;
  logic [3:0]  held, held_q;
  logic [3:0]  new_press;
  logic [8:0]  cnt_inc;

  // Fixed priority W > A > S > D; bit index equals the direction code.
  function automatic logic [1:0] pick(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Decode: any of the four slots may carry a key; duplicates merge.
  always_comb begin
    key_dec = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == KEY_W) key_dec[0] = 1'b1;
      if (keycode[8*i +: 8] == KEY_A) key_dec[1] = 1'b1;
      if (keycode[8*i +: 8] == KEY_S) key_dec[2] = 1'b1;
      if (keycode[8*i +: 8] == KEY_D) key_dec[3] = 1'b1;
    end
  end

  // Key sampling pipeline used for press-edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      held   <= '0;
      held_q <= '0;
    end else begin
      held   <= key_dec;
      held_q <= held;
    end
  end

  assign new_press = held & ~held_q;
  assign cnt_inc   = {1'b0, cnt_q} + 9'd1;

  // State, counter and direction registers; step is registered here too.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  // Arbitration first; a key change or release swallows a coincident tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (new_press != '0) begin
      state_d = FIRST;
      cnt_d   = '0;
      dir_d   = pick(new_press);
    end else if (held == '0) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE || !held[dir_q]) begin
      state_d = FIRST;
      cnt_d   = '0;
      dir_d   = pick(held);
    end else if (frame_tick) begin
      case (state_q)
        FIRST: begin
          step_d  = 1'b1;
          cnt_d   = '0;
          state_d = DELAY;
        end
        DELAY: begin
          if (cnt_inc == 9'(REPEAT_DELAY)) begin
            step_d  = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
        REPEAT: begin
          if (cnt_inc == 9'(REPEAT_RATE)) begin
            step_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_inc[7:0];
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign dir    = dir_q;
  assign step   = step_q;
  assign moving = (state_q != IDLE);

endmodule

// File: tb/tb_player_move_ctrl.sv
// Randomized bench for player_move_ctrl against a step-count/tick-count
// reference model, plus a few directed scenarios.
module tb_player_move_ctrl;

  localparam int unsigned RD = 8;
  localparam int unsigned RR = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic [31:0] keycode = '0;
  logic [1:0]  dir;
  logic        step;
  logic        moving;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned step_seen = 0;
  logic        chk_en = 1'b0;

  player_move_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode),
    .dir(dir), .step(step), .moving(moving)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: what a player would observe -- which key is active,
  // how many steps it has produced and how many ticks since the last one.
  logic [3:0] m_held = '0, m_prev = '0;
  int         m_active = 0;
  bit         m_moving = 0;
  int         m_nsteps = 0;
  int         m_ticks = 0;
  bit         m_step = 0;

  function automatic logic [3:0] decode(input logic [31:0] kc);
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) begin
      case (kc[8*i +: 8])
        8'h1A: v[0] = 1'b1;
        8'h04: v[1] = 1'b1;
        8'h16: v[2] = 1'b1;
        8'h07: v[3] = 1'b1;
        default: ;
      endcase
    end
    return v;
  endfunction

  function automatic int first_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge Clk) begin
    logic [3:0] np;
    int need;
    if (Reset) begin
      m_held = '0; m_prev = '0; m_active = 0; m_moving = 0;
      m_nsteps = 0; m_ticks = 0; m_step = 0;
    end else begin
      np = m_held & ~m_prev;
      m_step = 0;
      if (np != 0) begin
        m_active = first_of(np); m_moving = 1; m_nsteps = 0; m_ticks = 0;
      end else if (m_held == 0) begin
        m_moving = 0; m_nsteps = 0; m_ticks = 0;
      end else if (!m_moving || !m_held[m_active]) begin
        m_active = first_of(m_held); m_moving = 1; m_nsteps = 0; m_ticks = 0;
      end else if (frame_tick) begin
        m_ticks++;
        need = (m_nsteps == 0) ? 1 : (m_nsteps == 1) ? int'(RD) : int'(RR);
        if (m_ticks == need) begin
          m_step = 1;
          m_ticks = 0;
          if (m_nsteps < 2) m_nsteps++;
        end
      end
      m_prev = m_held;
      m_held = decode(keycode);
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("step", 32'(step), 32'(m_step));
      check("moving", 32'(moving), 32'(m_moving));
      check("dir", 32'(dir), 32'(m_active));
      if (step) step_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Holds keycode for n ticks spaced every 10 cycles.
  task automatic ticks10(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(9);
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
    end
  endtask

  initial begin
    int unsigned base;
    Reset = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    check("reset_dir", 32'(dir), 32'd0);
    check("reset_step", 32'(step), 32'd0);
    check("reset_moving", 32'(moving), 32'd0);
    Reset = 1'b0;
    cyc(2);

    // W held: steps on ticks 1, 9, 13, 17.
    keycode = 32'h0000001A;
    base = step_seen;
    ticks10(1);  cyc(1); check("w_tick1", step_seen - base, 1);
    ticks10(7);  cyc(1); check("w_tick8", step_seen - base, 1);
    ticks10(1);  cyc(1); check("w_tick9", step_seen - base, 2);
    ticks10(8);  cyc(1); check("w_tick17", step_seen - base, 4);

    // Reset during repeat with W held, then first step on first tick.
    Reset = 1'b1; cyc(1); Reset = 1'b0;
    check("rst_moving", 32'(moving), 32'd0);
    base = step_seen;
    ticks10(1); cyc(1); check("rst_restart", step_seen - base, 1);

    // Release between ticks: dir holds, no further steps.
    keycode = '0; cyc(3);
    check("rel_dir", 32'(dir), 32'd0);
    base = step_seen;
    ticks10(3); check("rel_nostep", step_seen - base, 0);

    // A for 3 ticks, then add D.
    keycode = 32'h00000004; ticks10(3);
    keycode = 32'h00000704; cyc(3);
    check("ad_dir", 32'(dir), 32'd3);
    base = step_seen;
    ticks10(1); cyc(1); check("ad_step", step_seen - base, 1);

    // All four at once, then release W.
    keycode = '0; cyc(3);
    keycode = 32'h1A041607; cyc(3);
    check("all_dir", 32'(dir), 32'd0);
    keycode = 32'h00041607; cyc(3);
    check("relw_dir", 32'(dir), 32'd1);

    // Press coincident with tick: no step on that tick.
    keycode = '0; cyc(3);
    keycode = 32'h00000016; cyc(1);
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
    base = step_seen;
    cyc(3); check("coinc_nostep", step_seen - base, 0);
    ticks10(1); cyc(1); check("coinc_next", step_seen - base, 1);

    // Two-cycle tick counts as two ticks.
    cyc(2); frame_tick = 1'b1; cyc(2); frame_tick = 1'b0; cyc(3);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        logic [31:0] kc;
        for (int b = 0; b < 4; b++) begin
          case ($urandom_range(0, 7))
            0: kc[8*b +: 8] = 8'h1A;
            1: kc[8*b +: 8] = 8'h04;
            2: kc[8*b +: 8] = 8'h16;
            3: kc[8*b +: 8] = 8'h07;
            4: kc[8*b +: 8] = 8'($urandom);
            default: kc[8*b +: 8] = 8'h00;
          endcase
        end
        keycode = kc;
      end
      frame_tick = ($urandom_range(0, 2) == 0);
      Reset = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    Reset = 1'b0; frame_tick = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 8: frame ticks from first step to first auto-repeat step; legal range 1..255.
REQ-002 SHALL have parameter REPEAT_RATE, default 4: frame ticks between auto-repeat steps; legal range 1..255.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-Clk-cycle pulse per video frame.
REQ-006 keycode  input  32  four USB HID usage bytes; 8'h00 means empty slot.
REQ-007 dir  output  2  active direction: 0=W/up, 1=A/left, 2=S/down, 3=D/right.
REQ-008 step  output  1  one-cycle pulse: move one unit in dir.
REQ-009 moving  output  1  high while any direction key is held and arbitrated.

Function
REQ-010 Key decode SHALL match any of the four keycode bytes: W=8'h1A, A=8'h04, S=8'h16, D=8'h07; duplicate bytes equal one press.
REQ-011 Decoded vector SHALL be registered every cycle into held[3:0]; previous value kept in held_q[3:0]; new_press = held & ~held_q.
REQ-012 Arbitration: any new_press bit SHALL make that key active; several in one cycle resolve by fixed priority W>A>S>D.
REQ-013 Active key released with others still held: highest-priority held key (W>A>S>D) SHALL become active, treated as a new press.
REQ-014 Active key still held and no new_press: active key SHALL be kept (most-recent-press wins, e.g. holding A then pressing D gives D).
REQ-015 FSM states IDLE, FIRST, DELAY, REPEAT; one 8-bit frame-tick counter cnt.
REQ-016 IDLE: moving=0, frame_tick ignored; active-key selection -> FIRST.
REQ-017 FIRST: next frame_tick -> step pulse, cnt=0, -> DELAY.
REQ-018 DELAY: each frame_tick increments cnt; the tick on which cnt+1 == REPEAT_DELAY -> step pulse, cnt=0, -> REPEAT.
REQ-019 REPEAT: the tick on which cnt+1 == REPEAT_RATE -> step pulse, cnt=0; otherwise increment on tick.
REQ-020 Any state except IDLE: active-key change (REQ-012/013) -> FIRST, cnt=0; all keys released -> IDLE, cnt=0.
REQ-021 Active-key change or release SHALL take precedence over a coincident frame_tick; that tick produces no step and is discarded.
REQ-022 step SHALL be registered: asserted in the cycle after the qualifying frame_tick cycle, high exactly one cycle.
REQ-023 dir SHALL update when the active key changes and hold otherwise, including in IDLE; dir SHALL be stable in every step cycle.
REQ-024 moving SHALL be 1 in FIRST, DELAY, REPEAT and 0 in IDLE.
REQ-025 Latency: keycode change in cycle t -> held in t+1 -> state/dir updated at t+2; earliest step at t+3, given frame_tick in t+2.
REQ-026 Never more than one step per frame_tick; frame_tick held high for two cycles counts as two ticks.

Reset
REQ-027 Reset SHALL force state=IDLE, cnt=0, held=0, held_q=0, dir=0, step=0, moving=0 on the next edge, overriding all other inputs.
REQ-028 Reset mid-operation SHALL drop any pending step; a key held through reset SHALL be seen as a new press after reset deasserts.

Verification
REQ-029 keycode=32'h0000001A held, ticks every 10 cycles -> dir=0, steps at tick 1, 9, 13, 17 (REPEAT_DELAY=8, REPEAT_RATE=4).
REQ-030 Hold A (8'h04) for 3 ticks, then add D (32'h00000704) -> dir changes to 3, next tick gives step with dir=3, repeat timing restarts.
REQ-031 keycode=32'h1A041607 appears from all-zero in one cycle -> dir=0 (W priority); release W -> dir=1, step on next tick.
REQ-032 New press coincident with frame_tick -> no step on that tick; step on following tick.
REQ-033 Assert Reset for 1 cycle during REPEAT with W held -> outputs zero next cycle; after reset, FIRST sequence restarts, step on first tick.
REQ-034 All keys released between ticks -> moving=0 next cycle, no further step, dir holds last value.
